// File: rtl/fetch_control_pkg.sv
// lc3b_types: shared state encoding and defaults for the LC-3b fetch sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package lc3b_types;

    // Read-wait cycles added to FETCH2 when the instantiating block does not override it.
    localparam int FETCH_MEM_WAIT_DEFAULT = 1;

    // Encodings are visible on state_out, so they are fixed rather than tool-chosen.
    typedef enum logic [2:0] {
        HALTED = 3'd0,
        FETCH1 = 3'd1,
        FETCH2 = 3'd2,
        FETCH3 = 3'd3,
        PAUSE  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_control_if.sv
// fetch_control_if: start/step requests into the sequencer and datapath/SRAM controls out of it.
// Latency: none (wiring only).
// Backpressure: none; master drives controls, slave (datapath/board) drives Run/Continue.
interface fetch_control_if;
    logic       Run;
    logic       Continue;
    logic       load_mar;
    logic       load_pc;
    logic       load_mdr;
    logic       load_ir;
    logic       GatePC;
    logic       GateMDR;
    logic       Mem_CE;
    logic       Mem_OE;
    logic       Mem_WE;
    logic [2:0] state_out;
    logic       fetch_done;

    modport master (
        input  Run, Continue,
        output load_mar, load_pc, load_mdr, load_ir, GatePC, GateMDR,
        output Mem_CE, Mem_OE, Mem_WE, state_out, fetch_done
    );

    modport slave (
        output Run, Continue,
        input  load_mar, load_pc, load_mdr, load_ir, GatePC, GateMDR,
        input  Mem_CE, Mem_OE, Mem_WE, state_out, fetch_done
    );
endinterface

// File: rtl/fetch_control_edge_rise.sv
// edge_rise: one-cycle pulse when a level input goes from 0 to 1.
// Latency: combinational pulse in the first cycle the input is seen high.
// Backpressure: none; reset value 1 so a level already high at reset release never fires.
module edge_rise (
    input  logic Clk,
    input  logic Reset,
    input  logic in,
    output logic rise
);
    logic in_q;

    // Remember last cycle's level; held at 1 through reset to mask held buttons.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;
endmodule

// File: rtl/fetch_control.sv
// fetch_control: LC-3b fetch sequencer MAR<-PC/PC+1, MDR<-M[MAR], IR<-MDR; macro ISDU_PAUSE_EN adds single-step PAUSE.
// Latency: Run edge -> FETCH1 next clock; one instruction per 3+MEM_WAIT cycles; outputs are Moore decodes.
// Backpressure: none; Run/Continue edges are taken only in HALTED/PAUSE and dropped in any other state.
module fetch_control
    import lc3b_types::*;
#(
    parameter int MEM_WAIT = FETCH_MEM_WAIT_DEFAULT
) (
    input  logic            Clk,
    input  logic            Reset,
    fetch_control_if.master bus
);
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [3:0]   wait_cnt;
    logic [3:0]   wait_cnt_next;
    logic         run_rise;

    logic load_mar;
    logic load_pc;
    logic load_mdr;
    logic load_ir;
    logic gate_pc;
    logic gate_mdr;
    logic mem_ce;
    logic mem_oe;
    logic fetch_done;

    edge_rise u_run_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .in    (bus.Run),
        .rise  (run_rise)
    );

`ifdef ISDU_PAUSE_EN
    logic cont_rise;

    edge_rise u_cont_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .in    (bus.Continue),
        .rise  (cont_rise)
    );
`else
    // Continue has no meaning when the sequencer free-runs.
    logic unused_continue;
    assign unused_continue = bus.Continue;
`endif

    // State and read-wait counter; async reset drops the bus immediately via the Moore decode.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= HALTED;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state and Moore output decode; gates and SRAM read never overlap on Data.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        load_mar      = 1'b0;
        load_pc       = 1'b0;
        load_mdr      = 1'b0;
        load_ir       = 1'b0;
        gate_pc       = 1'b0;
        gate_mdr      = 1'b0;
        mem_ce        = 1'b1;
        mem_oe        = 1'b1;
        fetch_done    = 1'b0;
        case (state)
            HALTED: begin
                if (run_rise) begin
                    state_next = FETCH1;
                end
            end
            FETCH1: begin
                gate_pc       = 1'b1;
                load_mar      = 1'b1;
                load_pc       = 1'b1;
                wait_cnt_next = WAIT_INIT;
                state_next    = FETCH2;
            end
            FETCH2: begin
                mem_ce = 1'b0;
                mem_oe = 1'b0;
                if (wait_cnt == 4'd0) begin
                    load_mdr   = 1'b1;
                    state_next = FETCH3;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            FETCH3: begin
                gate_mdr   = 1'b1;
                load_ir    = 1'b1;
                fetch_done = 1'b1;
`ifdef ISDU_PAUSE_EN
                state_next = PAUSE;
`else
                state_next = FETCH1;
`endif
            end
            PAUSE: begin
`ifdef ISDU_PAUSE_EN
                if (cont_rise) begin
                    state_next = FETCH1;
                end
`else
                state_next = HALTED;
`endif
            end
            default: begin
                state_next = HALTED;
            end
        endcase
    end

    assign bus.load_mar   = load_mar;
    assign bus.load_pc    = load_pc;
    assign bus.load_mdr   = load_mdr;
    assign bus.load_ir    = load_ir;
    assign bus.GatePC     = gate_pc;
    assign bus.GateMDR    = gate_mdr;
    assign bus.Mem_CE     = mem_ce;
    assign bus.Mem_OE     = mem_oe;
    assign bus.Mem_WE     = 1'b1;
    assign bus.state_out  = state;
    assign bus.fetch_done = fetch_done;
endmodule

// File: tb/tb_fetch_control.sv
// tb_fetch_control: two sequencers (MEM_WAIT=1 with a behavioural datapath, MEM_WAIT=0 bare) on shared Run/Continue.
// Latency: expected per-cycle outputs come from the fetch timeline (1 + (W+1) + 1 cycles per instruction).
// Backpressure: not applicable.
module tb_fetch_control;
    localparam int WA = 1;
    localparam int WB = 0;

    typedef struct packed {
        logic [2:0] st;
        logic gpc, gmdr, lmar, lpc, lmdr, lir, ce, oe, we, done;
    } obs_t;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic [15:0] mar;
    } log_t;

    logic clk = 1'b0;
    logic rst_n;
    logic run;
    logic cont;
    int   tests = 0;
    int   fails = 0;
    int   phase = 0;

    fetch_control_if ifa ();
    fetch_control_if ifb ();

    assign ifa.Run      = run;
    assign ifa.Continue = cont;
    assign ifb.Run      = run;
    assign ifb.Continue = cont;

    fetch_control #(.MEM_WAIT(WA)) u_dut_a (.Clk(clk), .Reset(rst_n), .bus(ifa.master));
    fetch_control #(.MEM_WAIT(WB)) u_dut_b (.Clk(clk), .Reset(rst_n), .bus(ifb.master));

    always #5 clk = ~clk;

    obs_t obs_a, obs_b;
    always_comb obs_a = {ifa.state_out, ifa.GatePC, ifa.GateMDR, ifa.load_mar, ifa.load_pc, ifa.load_mdr,
                         ifa.load_ir, ifa.Mem_CE, ifa.Mem_OE, ifa.Mem_WE, ifa.fetch_done};
    always_comb obs_b = {ifb.state_out, ifb.GatePC, ifb.GateMDR, ifb.load_mar, ifb.load_pc, ifb.load_mdr,
                         ifb.load_ir, ifb.Mem_CE, ifb.Mem_OE, ifb.Mem_WE, ifb.fetch_done};

    // Behavioural datapath and instruction SRAM sharing one Data bus, driven by instance A.
    logic [15:0] mem [256];
    logic [15:0] pc, mar, mdr, ir, data_bus;
    log_t        ir_log [$];

    always_comb begin
        if (ifa.GatePC)                    data_bus = pc;
        else if (ifa.GateMDR)              data_bus = mdr;
        else if (!ifa.Mem_CE && !ifa.Mem_OE) data_bus = mem[mar[7:0]];
        else                               data_bus = 16'hxxxx;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0; mar <= '0; mdr <= '0; ir <= '0;
        end else begin
            if (ifa.load_mar) mar <= data_bus;
            if (ifa.load_pc)  pc  <= pc + 16'd1;
            if (ifa.load_mdr) mdr <= data_bus;
            if (ifa.load_ir) begin
                ir <= data_bus;
                ir_log.push_back('{ir: data_bus, pc: pc, mar: mar});
            end
        end
    end

    // Bus-safety rules on both instances, every cycle.
    always @(negedge clk) begin
        tests += 3;
        if ((obs_a.gpc & obs_a.gmdr) | (obs_b.gpc & obs_b.gmdr)) begin
            fails++; $display("FAIL both_gates a=%b%b b=%b%b want never both 1", obs_a.gpc, obs_a.gmdr, obs_b.gpc, obs_b.gmdr);
        end
        if ((~obs_a.oe & (obs_a.gpc | obs_a.gmdr)) | (~obs_b.oe & (obs_b.gpc | obs_b.gmdr))) begin
            fails++; $display("FAIL oe_vs_gate a=%h b=%h want no OE with gate", obs_a, obs_b);
        end
        if (obs_a.we !== 1'b1 || obs_b.we !== 1'b1) begin
            fails++; $display("FAIL mem_we a=%b b=%b want 1", obs_a.we, obs_b.we);
        end
    end

    // Reference: idle outputs in a waiting state, and output k of a fetch with W read-wait cycles.
    function automatic obs_t exp_idle(logic [2:0] st);
        obs_t o;
        o = '0; o.st = st; o.ce = 1'b1; o.oe = 1'b1; o.we = 1'b1;
        return o;
    endfunction

    function automatic obs_t exp_fetch_cycle(int k, int w);
        obs_t o;
        o = exp_idle(3'd0);
        if (k == 0) begin
            o.st = 3'd1; o.gpc = 1'b1; o.lmar = 1'b1; o.lpc = 1'b1;
        end else if (k <= w + 1) begin
            o.st = 3'd2; o.ce = 1'b0; o.oe = 1'b0; o.lmdr = (k == w + 1);
        end else begin
            o.st = 3'd3; o.gmdr = 1'b1; o.lir = 1'b1; o.done = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t exp_after_start(int i, int w);
`ifdef ISDU_PAUSE_EN
        if (i < w + 3) return exp_fetch_cycle(i, w);
        return exp_idle(3'd4);
`else
        return exp_fetch_cycle(i % (w + 3), w);
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; cont = 1'b1;
        ir_log.delete();
        repeat (2) @(negedge clk);
        tests++;
        if (obs_a !== exp_idle(3'd0)) begin fails++; $display("FAIL reset_held got=%h want=%h", obs_a, exp_idle(3'd0)); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (obs_a !== exp_idle(3'd0) || obs_b !== exp_idle(3'd0)) begin
                fails++; $display("FAIL reset_release[%0d] a=%h b=%h want=%h", i, obs_a, obs_b, exp_idle(3'd0));
            end
        end
        cont = 1'b0; @(negedge clk); cont = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (obs_a !== exp_idle(3'd0)) begin fails++; $display("FAIL halted_ignores_continue got=%h want=%h", obs_a, exp_idle(3'd0)); end
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_fetch();
        obs_t ca [$];
        obs_t cb [$];
        run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ca.push_back(obs_a); cb.push_back(obs_b);
        end
        run = 1'b0;
        phase = 7;
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (ca[i] !== exp_after_start(i, WA)) begin fails++; $display("FAIL first_fetch_a[%0d] got=%h want=%h", i, ca[i], exp_after_start(i, WA)); end
            tests++;
            if (cb[i] !== exp_after_start(i, WB)) begin fails++; $display("FAIL first_fetch_b[%0d] got=%h want=%h", i, cb[i], exp_after_start(i, WB)); end
        end
        tests++;
        if (ir_log.size() < 1) begin
            fails++; $display("FAIL first_fetch_log got=%0d entries want>=1", ir_log.size());
        end else if (ir_log[0].ir !== mem[0] || ir_log[0].pc !== 16'd1 || ir_log[0].mar !== 16'd0) begin
            fails++; $display("FAIL first_fetch_regs got ir=%h pc=%h mar=%h want ir=%h pc=0001 mar=0000",
                              ir_log[0].ir, ir_log[0].pc, ir_log[0].mar, mem[0]);
        end
`ifdef ISDU_PAUSE_EN
        tests++;
        if (mdr !== mem[0] || ir !== mem[0]) begin fails++; $display("FAIL first_fetch_mdr got mdr=%h ir=%h want %h", mdr, ir, mem[0]); end
`endif
    endtask

`ifdef ISDU_PAUSE_EN
    task automatic test_continue_step();
        int hold = $urandom_range(3, 8);
        int da = 0;
        int db = 0;
        cont = 1'b0; @(negedge clk);
        cont = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == hold) cont = 1'b0;
            da += int'(obs_a.done); db += int'(obs_b.done);
        end
        tests++;
        if (da != 1 || db != 1) begin fails++; $display("FAIL continue_once got a=%0d b=%0d fetches want 1", da, db); end
        tests++;
        if (ir_log.size() != 2 || ir_log[1].ir !== mem[1] || ir_log[1].pc !== 16'd2) begin
            fails++; $display("FAIL continue_regs got n=%0d ir=%h pc=%h want n=2 ir=%h pc=0002",
                              ir_log.size(), ir, pc, mem[1]);
        end
        run = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (obs_a !== exp_idle(3'd4) || obs_b !== exp_idle(3'd4)) begin
            fails++; $display("FAIL pause_ignores_run a=%h b=%h want=%h", obs_a, obs_b, exp_idle(3'd4));
        end
        run = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 2; k < 6; k++) begin
            cont = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            cont = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (i == 6) cont = 1'($urandom);
                tests++;
                if (obs_a !== exp_after_start(i, WA) || obs_b !== exp_after_start(i, WB)) begin
                    fails++; $display("FAIL step%0d[%0d] a=%h b=%h want a=%h b=%h", k, i, obs_a, obs_b,
                                      exp_after_start(i, WA), exp_after_start(i, WB));
                end
            end
            tests++;
            if (ir_log.size() != k + 1 || ir_log[k].ir !== mem[k] || ir_log[k].pc !== 16'(k + 1) || ir_log[k].mar !== 16'(k)) begin
                fails++; $display("FAIL step%0d_regs got n=%0d ir=%h pc=%h want ir=%h pc=%0d", k, ir_log.size(), ir, pc, mem[k], k + 1);
            end
        end
    endtask
`else
    task automatic test_free_run();
        int exp_n = 0;
        for (int i = 0; i < 36; i++) begin
            cont = 1'($urandom);
            if ($urandom_range(0, 3) == 0) run = ~run;
            @(negedge clk);
            tests++;
            if (obs_a !== exp_after_start(phase, WA) || obs_b !== exp_after_start(phase, WB)) begin
                fails++; $display("FAIL free_run[%0d] a=%h b=%h want a=%h b=%h", phase, obs_a, obs_b,
                                  exp_after_start(phase, WA), exp_after_start(phase, WB));
            end
            phase++;
        end
        for (int c = 0; c <= phase - 2; c++) if (c % (WA + 3) == WA + 2) exp_n++;
        tests++;
        if (ir_log.size() != exp_n) begin fails++; $display("FAIL free_run_count got=%0d want=%0d", ir_log.size(), exp_n); end
        for (int j = 0; j < ir_log.size() && j < exp_n; j++) begin
            tests++;
            if (ir_log[j].ir !== mem[j % 256] || ir_log[j].pc !== 16'(j + 1) || ir_log[j].mar !== 16'(j)) begin
                fails++; $display("FAIL free_run_fetch%0d got ir=%h pc=%h mar=%h want ir=%h pc=%0d mar=%0d",
                                  j, ir_log[j].ir, ir_log[j].pc, ir_log[j].mar, mem[j % 256], j + 1, j);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_fetch();
        bit found = 1'b0;
`ifdef ISDU_PAUSE_EN
        cont = 1'b0; @(negedge clk); cont = 1'b1;
`endif
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (obs_a.st == 3'd2 && obs_a.lmdr) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL reset_mid_wait got no FETCH2 read cycle within 20 cycles want one");
        end else begin
            rst_n = 1'b0;
            #1;
            tests++;
            if (obs_a !== exp_idle(3'd0) || obs_b !== exp_idle(3'd0)) begin
                fails++; $display("FAIL reset_async a=%h b=%h want=%h", obs_a, obs_b, exp_idle(3'd0));
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (obs_a !== exp_idle(3'd0) || obs_b !== exp_idle(3'd0)) begin
            fails++; $display("FAIL reset_then_halted a=%h b=%h want=%h", obs_a, obs_b, exp_idle(3'd0));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        test_reset();
        test_first_fetch();
`ifdef ISDU_PAUSE_EN
        test_continue_step();
        test_back_to_back();
`else
        test_free_run();
`endif
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
